// File: rtl/cvp14_core_if.sv
// rtl/cvp14_core_if.sv - memory bus between the cvp14 core and its word memory.
interface cvp14_core_if;
  logic [15:0] DataIn;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataOut;
  logic        V;

  modport master (input DataIn, output Addr, RD, WR, DataOut, V);
  modport slave  (output DataIn, input Addr, RD, WR, DataOut, V);
endinterface

// File: rtl/cvp14_core.sv
// rtl/cvp14_core.sv - multicycle 16-bit scalar core, registered memory bus.
// Optional CVP14_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module cvp14_core #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_ADDR = 16'hFFFF
) (
  input  logic         Clk1,
  input  logic         Reset,
  cvp14_core_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_LWAIT, S_HALT
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n, ir, ir_n;
  logic [15:0] addr_q, addr_n, dout_q, dout_n;
  logic        rd_q, rd_n, wr_q, wr_n, v_q, v_n;
  logic [15:0] regs [8];
  logic        we;
  logic [15:0] wdata;

  logic [3:0]  op;
  logic [2:0]  f_rd, f_rs, f_rt;
  logic [15:0] a, b, sum, diff, add_res, sub_res, ea;
  logic        ovf_add, ovf_sub;

  assign op   = ir[15:12];
  assign f_rd = ir[11:9];
  assign f_rs = ir[8:6];
  assign f_rt = ir[5:3];
  assign a    = regs[f_rs];
  assign b    = regs[f_rt];
  assign sum  = a + b;
  assign diff = a - b;
  assign ea   = a + {{10{ir[5]}}, ir[5:0]};

  assign ovf_add = (a[15] == b[15]) && (sum[15] != a[15]);
  assign ovf_sub = (a[15] != b[15]) && (diff[15] != a[15]);

`ifdef CVP14_SAT_EN
  // On overflow the true result has the sign of operand a.
  assign add_res = ovf_add ? (a[15] ? 16'h8000 : 16'h7FFF) : sum;
  assign sub_res = ovf_sub ? (a[15] ? 16'h8000 : 16'h7FFF) : diff;
`else
  assign add_res = sum;
  assign sub_res = diff;
`endif

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      addr_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      dout_q <= '0;
      v_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir     <= ir_n;
      addr_q <= addr_n;
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      dout_q <= dout_n;
      v_q    <= v_n;
      if (we) regs[f_rd] <= wdata;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    addr_n  = '0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    dout_n  = '0;
    v_n     = v_q;
    we      = 1'b0;
    wdata   = '0;
    case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        ir_n    = bus.DataIn;
        pc_n    = pc + 16'd1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_FETCH;
        case (op)
          4'h0: begin we = 1'b1; wdata = add_res; v_n = ovf_add; end
          4'h1: begin we = 1'b1; wdata = sub_res; v_n = ovf_sub; end
          4'h2: begin we = 1'b1; wdata = a & b; end
          4'h3: begin we = 1'b1; wdata = a | b; end
          4'h4: begin we = 1'b1; wdata = {{8{ir[7]}}, ir[7:0]}; end
          4'h5: begin we = 1'b1; wdata = {ir[7:0], regs[f_rd][7:0]}; end
          4'h6: begin state_n = S_MEM; addr_n = ea; rd_n = 1'b1; end
          4'h7: begin
            state_n = S_MEM;
            addr_n  = ea;
            wr_n    = 1'b1;
            dout_n  = regs[f_rd];
          end
          4'h8: if (regs[f_rd] == 16'h0000) pc_n = pc + {{7{ir[8]}}, ir[8:0]};
          4'h9: pc_n = pc + {{4{ir[11]}}, ir[11:0]};
          4'hF: state_n = S_HALT;
          default: ;
        endcase
      end
      S_MEM:    state_n = (op == 4'h6) ? S_LWAIT : S_FETCH;
      S_LWAIT: begin
        we      = 1'b1;
        wdata   = bus.DataIn;
        state_n = S_FETCH;
      end
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase
    // Bus values are staged one cycle ahead so every output comes from a flop.
    if (state_n == S_FETCH) begin
      addr_n = pc_n;
      rd_n   = 1'b1;
    end
    if (state_n == S_HALT) addr_n = HALT_ADDR;
  end

  assign bus.Addr    = addr_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.DataOut = dout_q;
  assign bus.V       = v_q;

endmodule

// File: tb/tb_cvp14_core.sv
// tb/tb_cvp14_core.sv - scoreboard bench for cvp14_core: programs in a word memory,
// expected stores queued up front and popped as the core writes.
module tb_cvp14_core;

  logic Clk1  = 1'b0;
  logic Reset = 1'b0;

  cvp14_core_if bus ();

  cvp14_core dut (
    .Clk1  (Clk1),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk1 = ~Clk1;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem  [256];
  logic [15:0] wmem [256];
  logic        wval [256];
  logic [31:0] sb [$];

`ifdef CVP14_SAT_EN
  localparam logic [15:0] ADD_OVF = 16'h7FFF;
  localparam logic [15:0] SUB_OVF = 16'h8000;
`else
  localparam logic [15:0] ADD_OVF = 16'h8000;
  localparam logic [15:0] SUB_OVF = 16'h7FFF;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [7:0] imm8);
    return {op, rd, 1'b0, imm8};
  endfunction

  function automatic logic [15:0] enc_m(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] imm6);
    return {op, rd, rs, imm6};
  endfunction

  // Word memory: read data valid the cycle after RD, stores shadowed in wmem.
  always @(posedge Clk1) begin
    if (!Reset) begin
      for (int i = 0; i < 256; i++) wval[i] <= 1'b0;
    end else begin
      if (bus.RD) bus.DataIn <= wval[bus.Addr[7:0]] ? wmem[bus.Addr[7:0]] : mem[bus.Addr[7:0]];
      if (bus.WR) begin
        wmem[bus.Addr[7:0]] <= bus.DataOut;
        wval[bus.Addr[7:0]] <= 1'b1;
      end
    end
  end

  always @(negedge Clk1) begin
    logic [31:0] e;
    if (Reset) begin
      if (bus.WR) begin
        chk("rd_wr_excl", {31'd0, bus.RD}, 32'd0);
        if (sb.size() == 0) chk("sb_extra_wr", sb.size(), 32'd1);
        else begin
          e = sb.pop_front();
          chk("st_addr", {16'd0, bus.Addr}, {16'd0, e[31:16]});
          chk("st_data", {16'd0, bus.DataOut}, {16'd0, e[15:0]});
        end
      end else begin
        chk("dout_idle", {16'd0, bus.DataOut}, 32'd0);
      end
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic run_prog(input string tag, input int exp_cyc, input logic exp_v,
                          input int probe_n, input logic [15:0] probe_addr);
    int   n;
    logic halted;
    Reset = 1'b0;
    repeat (2) @(negedge Clk1);
    chk({tag, "_rst_addr"}, {16'd0, bus.Addr}, 32'd0);
    chk({tag, "_rst_rdwr"}, {30'd0, bus.RD, bus.WR}, 32'd0);
    chk({tag, "_rst_dout"}, {16'd0, bus.DataOut}, 32'd0);
    chk({tag, "_rst_v"}, {31'd0, bus.V}, 32'd0);
    Reset  = 1'b1;
    n      = 0;
    halted = 1'b0;
    while (!halted && n < 400) begin
      @(negedge Clk1);
      n++;
      if (n == 1) begin
        chk({tag, "_first_fetch_addr"}, {16'd0, bus.Addr}, 32'h0000);
        chk({tag, "_first_fetch_rd"}, {31'd0, bus.RD}, 32'd1);
      end
      if (n == probe_n) begin
        chk({tag, "_probe_addr"}, {16'd0, bus.Addr}, {16'd0, probe_addr});
        chk({tag, "_probe_rd"}, {31'd0, bus.RD}, 32'd1);
      end
      if (bus.Addr == 16'hFFFF && !bus.RD) halted = 1'b1;
    end
    chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_v"}, {31'd0, bus.V}, {31'd0, exp_v});
    repeat (3) @(negedge Clk1);
    chk({tag, "_halt_addr"}, {16'd0, bus.Addr}, 32'hFFFF);
    chk({tag, "_halt_rdwr"}, {30'd0, bus.RD, bus.WR}, 32'd0);
    chk({tag, "_sb_left"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    // Bare HALT at the reset vector.
    clr_mem();
    run_prog("halt", 4, 1'b0, 0, 16'h0000);

    // Small positive ADD plus rd==rs self-add.
    clr_mem();
    mem[0] = enc_i(4'h4, 3'd1, 8'h7F);
    mem[1] = enc_i(4'h4, 3'd2, 8'h01);
    mem[2] = enc_r(4'h0, 3'd3, 3'd1, 3'd2);
    mem[3] = enc_m(4'h7, 3'd3, 3'd0, 6'h18);
    mem[4] = enc_r(4'h0, 3'd2, 3'd2, 3'd2);
    mem[5] = enc_m(4'h7, 3'd2, 3'd0, 6'h19);
    sb.push_back({16'h0018, 16'h0080});
    sb.push_back({16'h0019, 16'h0002});
    run_prog("add", 24, 1'b0, 0, 16'h0000);

    // Overflowing ADD and SUB; logic ops in between keep V.
    clr_mem();
    mem[0]  = enc_i(4'h4, 3'd1, 8'hFF);
    mem[1]  = enc_i(4'h5, 3'd1, 8'h7F);
    mem[2]  = enc_i(4'h4, 3'd2, 8'h01);
    mem[3]  = enc_r(4'h0, 3'd3, 3'd1, 3'd2);
    mem[4]  = enc_r(4'h2, 3'd6, 3'd1, 3'd2);
    mem[5]  = enc_r(4'h3, 3'd7, 3'd1, 3'd2);
    mem[6]  = enc_m(4'h7, 3'd3, 3'd0, 6'h18);
    mem[7]  = enc_m(4'h7, 3'd6, 3'd0, 6'h19);
    mem[8]  = enc_m(4'h7, 3'd7, 3'd0, 6'h1A);
    mem[9]  = enc_i(4'h4, 3'd4, 8'h00);
    mem[10] = enc_i(4'h5, 3'd4, 8'h80);
    mem[11] = enc_r(4'h1, 3'd5, 3'd4, 3'd2);
    mem[12] = enc_m(4'h7, 3'd5, 3'd0, 6'h1B);
    mem[13] = enc_r(4'h2, 3'd6, 3'd6, 3'd6);
    sb.push_back({16'h0018, ADD_OVF});
    sb.push_back({16'h0019, 16'h0001});
    sb.push_back({16'h001A, 16'h7FFF});
    sb.push_back({16'h001B, SUB_OVF});
    run_prog("ovf", 50, 1'b1, 0, 16'h0000);

    // Store then load back through the same address.
    clr_mem();
    mem[0] = enc_i(4'h4, 3'd1, 8'h10);
    mem[1] = enc_m(4'h7, 3'd1, 3'd1, 6'h02);
    mem[2] = enc_m(4'h6, 3'd4, 3'd1, 6'h02);
    mem[3] = enc_m(4'h7, 3'd4, 3'd0, 6'h08);
    sb.push_back({16'h0012, 16'h0010});
    sb.push_back({16'h0008, 16'h0010});
    run_prog("ldst", 20, 1'b0, 0, 16'h0000);

    // BZ at PC=5, taken.
    clr_mem();
    for (int i = 0; i < 5; i++) mem[i] = 16'hA000;
    mem[5] = {4'h8, 3'd0, 9'd2};
    mem[8] = enc_m(4'h7, 3'd0, 3'd0, 6'h01);
    sb.push_back({16'h0001, 16'h0000});
    run_prog("bz_taken", 26, 1'b0, 19, 16'h0008);

    // BZ at PC=5, not taken.
    clr_mem();
    mem[0] = enc_i(4'h4, 3'd0, 8'h01);
    for (int i = 1; i < 5; i++) mem[i] = 16'hA000;
    mem[5] = {4'h8, 3'd0, 9'd2};
    mem[6] = enc_m(4'h7, 3'd0, 3'd0, 6'h02);
    sb.push_back({16'h0003, 16'h0001});
    run_prog("bz_fall", 26, 1'b0, 19, 16'h0006);

    // Reset during the LD memory cycle aborts the load.
    clr_mem();
    mem[0] = enc_m(4'h6, 3'd1, 3'd0, 6'h03);
    mem[3] = 16'hBEEF;
    Reset = 1'b0;
    repeat (2) @(negedge Clk1);
    Reset = 1'b1;
    repeat (4) @(negedge Clk1);
    chk("ld_mem_rd", {31'd0, bus.RD}, 32'd1);
    chk("ld_mem_addr", {16'd0, bus.Addr}, 32'h0003);
    Reset = 1'b0;
    #1;
    chk("abort_rd", {31'd0, bus.RD}, 32'd0);
    chk("abort_addr", {16'd0, bus.Addr}, 32'd0);
    mem[0] = enc_m(4'h7, 3'd1, 3'd0, 6'h04);
    mem[1] = 16'hF000;
    sb.push_back({16'h0004, 16'h0000});
    run_prog("abort", 8, 1'b0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvp14_core.md
CVP14_CORE -- requirements
Module: cvp14

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_ADDR, default 16'hFFFF, address driven to signal end of program.
REQ-003 SHALL have port Clk1  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DataIn  input  16  read data from memory, valid the cycle after a read request.
REQ-006 SHALL have port Addr  output  16  memory word address.
REQ-007 SHALL have port RD  output  1  read request, one cycle per access.
REQ-008 SHALL have port WR  output  1  write request, one cycle per access.
REQ-009 SHALL have port DataOut  output  16  store data, valid while WR=1.
REQ-010 SHALL have port V  output  1  signed-overflow flag of the last ADD/SUB.

Function
REQ-011 SHALL be a multicycle scalar core: 16-bit PC, eight 16-bit registers R0-R7 (R0 writable), instruction fields op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0], imm8[7:0], imm9[8:0], imm12[11:0].
REQ-012 SHALL drive all outputs from registered state only; no combinational path from DataIn to any output.
REQ-013 SHALL sequence IDLE -> FETCH -> DECODE -> EXEC -> {FETCH | MEM -> (LWAIT) -> FETCH | HALT}.
REQ-014 FETCH: Addr=PC, RD=1; DECODE: IR<=DataIn, PC<=PC+1 (wraps 0xFFFF->0x0000).
REQ-015 Opcodes: 0 ADD rd=rs+rt; 1 SUB rd=rs-rt; 2 AND; 3 OR; 4 LLB rd=sext(imm8); 5 LHB rd={imm8,rd[7:0]}.
REQ-016 Opcode 6 LD: MEM cycle Addr=rs+sext(imm6), RD=1; LWAIT cycle rd<=DataIn.
REQ-017 Opcode 7 ST: MEM cycle Addr=rs+sext(imm6), WR=1, DataOut=R[rd]; no LWAIT.
REQ-018 Opcode 8 BZ: if R[rd]==0, PC<=PC+sext(imm9) (PC already incremented); opcode 9 J: PC<=PC+sext(imm12).
REQ-019 Opcode F HALT: enter HALT; Addr=HALT_ADDR, RD=0, WR=0 held until reset; opcodes A-E SHALL be NOPs.
REQ-020 Latencies: ALU/branch/NOP 3 cycles, ST 4, LD 5, FETCH to FETCH.
REQ-021 RD and WR SHALL never be 1 simultaneously; outside FETCH/MEM both 0, DataOut 0 when WR=0.
REQ-022 V SHALL update only on ADD/SUB (signed overflow of 16-bit two's-complement result), hold otherwise.
REQ-023 Address arithmetic SHALL wrap modulo 2^16; rd==rs/rt SHALL read old values before writeback.

Reset
REQ-024 While Reset=0: state IDLE, PC=RESET_PC, R0-R7=0, IR=0, V=0, Addr=0, RD=0, WR=0, DataOut=0.
REQ-025 First cycle after deassertion SHALL be IDLE, then FETCH of RESET_PC; reset mid-access aborts it with no register or memory update.

Configuration
REQ-026 With CVP14_SAT_EN defined, ADD/SUB on overflow SHALL write 0x7FFF (positive) or 0x8000 (negative); without it they SHALL wrap; V behaviour identical in both.

Verification
REQ-027 Reset release, mem[0]=F000 -> cycle 1 FETCH Addr=0000 RD=1, HALT then Addr=FFFF, RD=WR=0.
REQ-028 LLB R1,0x7F; LLB R2,0x01; ADD R3,R1,R2 -> R3=0x0080, V=0.
REQ-029 LLB R1,0xFF; LHB R1,0x7F; LLB R2,1; ADD R3,R1,R2 -> V=1, R3=0x8000 (wrap) or 0x7FFF (CVP14_SAT_EN).
REQ-030 LLB R1,0x10; ST R1,[R1+2]; LD R4,[R1+2] -> WR=1 Addr=0012 DataOut=0010 one cycle, R4=0x0010.
REQ-031 BZ R0,+2 with R0=0 at PC=5 -> next fetch Addr=0008; with R0=1 -> Addr=0006.
REQ-032 Reset asserted during LD MEM cycle -> RD drops immediately, rd unchanged (0), restart at RESET_PC.
